pipe_column_gen: RTL and testbench
==================================

# pipe_column_gen

Generates the obstacle column stream for the game datapath. Pipe heights are pseudo-random, drawn from a 16-bit Galois LFSR and folded into a legal height window. Each pipe is separated by a fixed run of empty columns. The block sits directly upstream of the datapath and replaces its fixed obstacle list: the datapath pulls one 7-bit column per scroll tick through a valid/ready handshake.

## Interface
- `GAP_COLS`, default 8: number of empty (height 0) columns before each pipe. Must be ≥1.
- `MIN_H`, default 10: lowest pipe-gap bottom height.
- `MAX_H`, default 50: highest pipe-gap bottom height. Range `R = MAX_H-MIN_H+1` must satisfy 32 ≤ R ≤ 64, and `MAX_H+24` must be ≤ 80.
- `SEED`, default 16'hACE1: LFSR load value. 0 is replaced by 16'h0001.

Ports:
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `restart` in 1: synchronous reload, driven by control `start`. Same effect as reset.
- `col_ready` in 1: consumer accepts the column this cycle.
- `col_valid` out 1: `col_height` holds a valid column.
- `col_height` out 7: 0 = empty column; nonzero = pipe-gap bottom height.
- `pipe_count` out 14: pipes emitted since reset/restart. Saturates at 16383.

## Operation
- States: `S_GAP` (current column is empty), `S_PIPE` (current column is a pipe).
- Reset/restart values: state=`S_GAP`, `gap_cnt`=0, `lfsr`=SEED, `col_height`=0, `col_valid`=0, `pipe_count`=0.
- First non-reset, non-restart cycle: `col_valid`←1. The current column is the first empty column.
- A transfer occurs when `col_valid & col_ready`. With no transfer, all outputs and state hold.
- Transfer in `S_GAP`:
  - If `gap_cnt==GAP_COLS-1`: `col_height`←`pipe_h(lfsr)`, lfsr advances, `gap_cnt`←0, state←`S_PIPE`.
  - Else: `col_height`←0, `gap_cnt`++.
- Transfer in `S_PIPE`: `col_height`←0, state←`S_GAP`, `pipe_count`++ (saturating).
- Resulting stream: `GAP_COLS` zeros, P0, `GAP_COLS` zeros, P1, …
- `pipe_h(v)`: `raw=v[5:0]`. Result is `MIN_H + (raw ≥ R ? raw-R : raw)`, computed in 7 bits with no overflow under the parameter constraints.
- LFSR step: `lfsr ← {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`. It steps only on a pipe load; never all-zero.
- Priority: reset > restart > transfer.

## Timing
- Registered outputs only. No combinational path from `col_ready` to any output.
- `col_valid` rises exactly 1 cycle after `reset`/`restart` deasserts.
- The next column is presented the cycle after a transfer. Sustained throughput is 1 column/cycle.
- Restart asserted mid-stream discards the current column. `col_valid` is 0 for the cycle following the restart, and the sequence repeats identically (same SEED gives same heights).
- `restart` held high keeps `col_valid`=0.
- `pipe_count` updates in the cycle after the transfer of a pipe column.

## Structure
- Shared package `flappy_pkg` holds:
  - `H_W`=7, `SCORE_W`=14, `GAP_BAND`=24, `FLOOR_H`=80
  - `LFSR_TAPS`=16'hB400
  - state enum {`S_GAP`, `S_PIPE`}
- Sub-module `lfsr16` (ports: `clk`, `reset`, `load`, `seed`, `step`, `q`) owns the LFSR and its zero-seed fix.
- `pipe_h` and the FSM/counters stay in the top level.

## Test plan
- Reset with `col_ready`=1 permanently → 8 zeros, 43, 8 zeros, 17 (SEED ACE1 → raw 33; next LFSR E270 → raw 48 folds to 7). `pipe_count`=2 after the second pipe.
- `col_ready` toggled pseudo-randomly → the column sequence is identical to the always-ready run, and `col_height` is stable whenever `col_valid & !col_ready`.
- `restart` pulsed after the 3rd pipe → `col_valid`=0 for one cycle, then the stream restarts at 8 zeros, 43. `pipe_count`=0.
- 10,000 pipes with default parameters → every nonzero `col_height` lies in [10,50], every run of zeros is exactly 8 long, and `pipe_count` never wraps. Force `pipe_count` to 16383 and check it saturates.
- `GAP_COLS`=1 and `SEED`=0 → stream alternates 0 / pipe, the LFSR starts at 0001, and the first pipe height is 11.

Source files
------------

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flappy_pkg
// Purpose  : Shared widths, playfield constants, LFSR taps and the column
//            generator state encoding for the game datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package flappy_pkg;

   localparam int H_W      = 7;    // column height width
   localparam int SCORE_W  = 14;   // pipe counter width
   localparam int GAP_BAND = 24;   // vertical opening of a pipe gap
   localparam int FLOOR_H  = 80;   // playfield height

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [0:0] {
      S_GAP  = 1'b0,
      S_PIPE = 1'b1
   } col_state_e;

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Galois LFSR (taps 0xB400). A zero seed is replaced by
//            0x0001 so the register can never lock up in the all-zero state.
// Ports    : clk   in  1  - clock
//            reset in  1  - synchronous active-high, loads the seed
//            load  in  1  - synchronous reload of the seed
//            seed  in  16 - load value
//            step  in  1  - advance one state
//            q     out 16 - current LFSR value
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
   import flappy_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic [15:0] seed_fix;

   assign seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         lfsr_q <= seed_fix;
      end else if (step) begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign q = lfsr_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/pipe_column_gen.sv
`default_nettype none
// ============================================================================
// Module   : pipe_column_gen
// Purpose  : Streams obstacle columns to the game datapath: GAP_COLS empty
//            columns followed by one pipe whose gap-bottom height is drawn
//            from an LFSR and folded into [MIN_H, MAX_H].
// Ports    : clk        in  1  - clock
//            reset      in  1  - synchronous active-high reset
//            restart    in  1  - synchronous reload (same effect as reset)
//            col_ready  in  1  - consumer accepts the current column
//            col_valid  out 1  - col_height holds a valid column
//            col_height out 7  - 0 = empty, else pipe-gap bottom height
//            pipe_count out 14 - saturating count of pipes transferred
// Revision : 1.0 - initial release
// ============================================================================
module pipe_column_gen
   import flappy_pkg::*;
#(
   parameter int          GAP_COLS = 8,
   parameter int          MIN_H    = 10,
   parameter int          MAX_H    = 50,
   parameter logic [15:0] SEED     = 16'hACE1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               restart,
   input  logic               col_ready,
   output logic               col_valid,
   output logic [H_W-1:0]     col_height,
   output logic [SCORE_W-1:0] pipe_count
);

   localparam int RANGE = MAX_H - MIN_H + 1;
   localparam int GC_W  = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;

   if (GAP_COLS < 1 || RANGE < 32 || RANGE > 64 || MAX_H + GAP_BAND > FLOOR_H) begin : g_bad_params
      $error("pipe_column_gen: illegal parameter combination");
   end

   // A 6-bit raw value is below 2*RANGE, so one conditional subtract folds it
   // into [0, RANGE-1].
   function automatic logic [H_W-1:0] pipe_h(input logic [5:0] raw);
      logic [H_W-1:0] r7;
      r7 = {1'b0, raw};
      if (r7 >= H_W'(RANGE)) begin
         r7 = r7 - H_W'(RANGE);
      end
      return H_W'(MIN_H) + r7;
   endfunction

   col_state_e          state_q;
   logic [GC_W-1:0]     gap_cnt_q;
   logic                col_valid_q;
   logic [H_W-1:0]      col_height_q;
   logic [SCORE_W-1:0]  pipe_count_q;

   logic [15:0]         lfsr_q;
   logic                xfer;
   logic                gap_last;
   logic                lfsr_step;
   logic                unused_lfsr_hi;

   assign xfer      = col_valid_q & col_ready;
   assign gap_last  = (gap_cnt_q == GC_W'(GAP_COLS - 1));
   assign lfsr_step = xfer & (state_q == S_GAP) & gap_last;

   // Only the low six bits feed the height fold.
   assign unused_lfsr_hi = ^lfsr_q[15:6];

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (restart),
      .seed  (SEED),
      .step  (lfsr_step),
      .q     (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state_q      <= S_GAP;
         gap_cnt_q    <= '0;
         col_valid_q  <= 1'b0;
         col_height_q <= '0;
         pipe_count_q <= '0;
      end else begin
         // The stream never runs dry, so valid stays high once out of reset.
         col_valid_q <= 1'b1;
         if (xfer) begin
            if (state_q == S_GAP) begin
               if (gap_last) begin
                  col_height_q <= pipe_h(lfsr_q[5:0]);
                  gap_cnt_q    <= '0;
                  state_q      <= S_PIPE;
               end else begin
                  col_height_q <= '0;
                  gap_cnt_q    <= gap_cnt_q + 1'b1;
               end
            end else begin
               col_height_q <= '0;
               state_q      <= S_GAP;
               if (pipe_count_q != '1) begin
                  pipe_count_q <= pipe_count_q + 1'b1;
               end
            end
         end
      end
   end

   assign col_valid  = col_valid_q;
   assign col_height = col_height_q;
   assign pipe_count = pipe_count_q;

endmodule : pipe_column_gen
`default_nettype wire

// File: tb/tb_pipe_column_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_column_gen
// Purpose  : Directed self-checking bench for pipe_column_gen. Instance A uses
//            default parameters; instance B uses GAP_COLS=1, SEED=0 and is run
//            long enough to saturate pipe_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_column_gen;

   logic        clk = 1'b0;
   logic        reset_a, restart_a, ready_a;
   logic        valid_a;
   logic [6:0]  height_a;
   logic [13:0] count_a;

   logic        reset_b, ready_b;
   logic        valid_b;
   logic [6:0]  height_b;
   logic [13:0] count_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_column_gen dut_a (
      .clk        (clk),
      .reset      (reset_a),
      .restart    (restart_a),
      .col_ready  (ready_a),
      .col_valid  (valid_a),
      .col_height (height_a),
      .pipe_count (count_a)
   );

   pipe_column_gen #(.GAP_COLS(1), .SEED(16'h0000)) dut_b (
      .clk        (clk),
      .reset      (reset_b),
      .restart    (1'b0),
      .col_ready  (ready_b),
      .col_valid  (valid_b),
      .col_height (height_b),
      .pipe_count (count_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [6:0]  prev_h;
      logic        prev_v;
      logic        r;
      logic [6:0]  seen [0:8];
      logic [13:0] prev_cnt;
      int          got;
      int          hold_err;
      int          b_err;
      int          exp_cnt;

      reset_a = 1'b1; restart_a = 1'b0; ready_a = 1'b1;
      reset_b = 1'b1; ready_b = 1'b1;
      tick; tick;

      // Reset state
      chk("rst_valid",  {31'd0, valid_a},  0);
      chk("rst_height", {25'd0, height_a}, 0);
      chk("rst_count",  {18'd0, count_a},  0);

      // Always-ready stream: 8 zeros, 43, 8 zeros, 17
      reset_a = 1'b0;
      tick;
      chk("first_valid", {31'd0, valid_a}, 1);
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("stream_col%0d", i), {25'd0, height_a},
             (i == 8) ? 43 : ((i == 17) ? 17 : 0));
         tick;
      end
      chk("count_after_2", {18'd0, count_a}, 2);
      chk("col18_zero",    {25'd0, height_a}, 0);

      // Full stall: everything holds
      ready_a = 1'b0;
      prev_h  = height_a;
      tick; tick; tick;
      chk("stall_valid",  {31'd0, valid_a},  1);
      chk("stall_height", {25'd0, height_a}, {25'd0, prev_h});
      chk("stall_count",  {18'd0, count_a},  2);

      // Random backpressure: columns 18..26 = 8 zeros then 25
      got = 0; hold_err = 0;
      for (int c = 0; c < 200 && got < 9; c++) begin
         r       = 1'($urandom_range(0, 1));
         ready_a = r;
         prev_h  = height_a;
         prev_v  = valid_a;
         tick;
         if (r && prev_v) begin
            seen[got] = prev_h;
            got++;
         end else if (height_a !== prev_h) begin
            hold_err++;
         end
      end
      chk("bp_transfers", got, 9);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("bp_col%0d", i), {25'd0, seen[i]}, (i == 8) ? 25 : 0);
      end
      chk("bp_hold", hold_err, 0);
      chk("count_after_3", {18'd0, count_a}, 3);

      // Restart mid-stream, held for two cycles
      ready_a   = 1'b1;
      restart_a = 1'b1;
      tick;
      chk("rs_valid",  {31'd0, valid_a},  0);
      chk("rs_count",  {18'd0, count_a},  0);
      chk("rs_height", {25'd0, height_a}, 0);
      tick;
      chk("rs_held_valid", {31'd0, valid_a}, 0);
      restart_a = 1'b0;
      tick;
      chk("rs_rise_valid", {31'd0, valid_a}, 1);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("rs_col%0d", i), {25'd0, height_a}, (i == 8) ? 43 : 0);
         tick;
      end
      chk("rs_count_after", {18'd0, count_a}, 1);

      // Instance B: GAP_COLS=1, SEED=0
      chk("b_seed_fix", {16'd0, dut_b.u_lfsr.q}, 32'h0001);
      reset_b = 1'b0;
      tick;
      b_err    = 0;
      prev_cnt = count_b;
      for (int i = 0; i < 32780; i++) begin
         if (i == 1) chk("b_pipe0", {25'd0, height_b}, 11);
         if (i == 3) chk("b_pipe1", {25'd0, height_b}, 10);
         exp_cnt = (i / 2 > 16383) ? 16383 : i / 2;
         if (valid_b !== 1'b1)                          b_err++;
         if ({18'd0, count_b} !== exp_cnt)              b_err++;
         if (count_b < prev_cnt)                        b_err++;
         if ((i % 2) == 0 && height_b !== 7'd0)          b_err++;
         if ((i % 2) == 1 && (height_b < 7'd10 || height_b > 7'd50)) b_err++;
         prev_cnt = count_b;
         tick;
      end
      chk("b_stream_errors", b_err, 0);
      chk("b_saturated", {18'd0, count_b}, 16383);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pipe_column_gen
`default_nettype wire
